// File: rtl/keypad_pkg.sv
// Shared key-code type, well-known key codes and MCU output-port bit positions
// for the keypad event queue.
package keypad_pkg;

    typedef logic [3:0] key_code_t;

    localparam key_code_t KEY_STAR      = 4'd10;
    localparam key_code_t KEY_POUND     = 4'd11;
    localparam key_code_t KEY_MAX_VALID = 4'd11;
    localparam key_code_t KEY_NONE      = 4'd13;

    localparam int DOUT_VALID_BIT = 7;
    localparam int DOUT_OVF_BIT   = 6;

endpackage

// File: rtl/sync_fifo_core.sv
// Show-ahead synchronous FIFO: the head entry is visible on rdata_o whenever
// the queue is non-empty. A push into a full queue succeeds only alongside a pop.
module sync_fifo_core #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

    // A pop frees the slot the concurrent push needs, so full+pop still accepts.
    assign do_push = push_i & (~full_o | pop_i);
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/keypad_event_queue.sv
// Captures keypad driver events (key_intr rising edges) into a show-ahead queue
// for the MCU. Define KEY_ECHO_FILTER_EN to suppress repeats of the same code within HOLDOFF cycles.
module keypad_event_queue
    import keypad_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int HOLDOFF = 1000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   key_intr,
    input  logic [3:0]             key_code,
    input  logic                   rd_strobe,
    output logic [7:0]             dout,
    output logic                   cpu_intr,
    output logic [$clog2(DEPTH):0] count
);

    // Reject unusable configurations at elaboration rather than misbehave silently.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLDOFF < 1) begin : g_bad_params
        $error("keypad_event_queue: DEPTH must be a power of 2 >= 2 and HOLDOFF >= 1");
    end

    logic      key_intr_q;
    logic      ovf_q;
    logic      rise;
    logic      candidate;
    logic      accept;
    logic      drop;
    logic      pop_ok;
    logic      fifo_full;
    logic      fifo_empty;
    key_code_t head_code;

    assign rise      = key_intr & ~key_intr_q;
    assign candidate = rise & (key_code <= KEY_MAX_VALID);

`ifdef KEY_ECHO_FILTER_EN
    localparam int HW = $clog2(HOLDOFF + 1);

    logic [HW-1:0] hold_cnt_q;
    key_code_t     last_code_q;

    assign accept = candidate & ~((key_code == last_code_q) && (hold_cnt_q != '0));

    // Events dropped on a full queue still restart the window: the key was seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q  <= '0;
            last_code_q <= 4'hF;
        end else if (accept) begin
            hold_cnt_q  <= HW'(HOLDOFF);
            last_code_q <= key_code;
        end else if (hold_cnt_q != '0) begin
            hold_cnt_q  <= hold_cnt_q - 1'b1;
        end
    end
`else
    assign accept = candidate;
`endif

    assign drop   = accept & fifo_full & ~rd_strobe;
    assign pop_ok = rd_strobe & ~fifo_empty;

    sync_fifo_core #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(key_code_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .pop_i   (rd_strobe),
        .wdata_i (key_code),
        .rdata_o (head_code),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // History resets high so a key already held at reset release is not an event.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_intr_q <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            key_intr_q <= key_intr;
            if (drop)        ovf_q <= 1'b1;
            else if (pop_ok) ovf_q <= 1'b0;
        end
    end

    always_comb begin
        dout                 = 8'h00;
        dout[DOUT_VALID_BIT] = ~fifo_empty;
        dout[DOUT_OVF_BIT]   = ovf_q;
        dout[3:0]            = fifo_empty ? 4'h0 : head_code;
    end

    assign cpu_intr = ~fifo_empty;

endmodule
